// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, FSM states,
// register/ALU function codes, ARF indices, mux selects and the control word.
package cpu_pkg;

   // ISA opcodes (IR[15:12])
   localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4, OP_NOT = 4'h5, OP_LSL = 4'h6, OP_LSR = 4'h7;
   localparam logic [3:0] OP_LDI  = 4'h8, OP_LDM = 4'h9, OP_STM = 4'hA, OP_LDAR = 4'hB;
   localparam logic [3:0] OP_BRA  = 4'hC, OP_BEQ = 4'hD, OP_NOP = 4'hE, OP_HLT  = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH1 = 3'd0,
      S_FETCH2 = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC1  = 3'd3,
      S_EXEC2  = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   // Register function codes (IR, ARF, RF)
   localparam logic [1:0] FS_DEC = 2'b00, FS_INC = 2'b01, FS_LOAD = 2'b10, FS_CLEAR = 2'b11;

   // ALU function codes
   localparam logic [3:0] ALU_PASSA = 4'h0, ALU_NOT = 4'h2, ALU_ADD = 4'h4, ALU_SUB = 4'h5;
   localparam logic [3:0] ALU_AND   = 4'h7, ALU_OR  = 4'h8, ALU_XOR = 4'h9, ALU_LSL = 4'hB;
   localparam logic [3:0] ALU_LSR   = 4'hC;

   // ARF register indices
   localparam logic [1:0] ARF_PC = 2'd0, ARF_AR = 2'd1, ARF_SP = 2'd2;

   // RF/ARF input mux and ALU A mux selects
   localparam logic [1:0] MUX_ALU = 2'b00, MUX_MEM = 2'b01, MUX_IMM = 2'b10, MUX_ARFA = 2'b11;
   localparam logic       MUXC_ARF = 1'b0, MUXC_RF = 1'b1;

   typedef struct packed {
      logic       halted;
      logic [1:0] outasel;
      logic [1:0] outbsel;
      logic [1:0] funsel_ir;
      logic [1:0] funsel_arf;
      logic [1:0] funsel_rf;
      logic [3:0] funsel_alu;
      logic [3:0] regsel_rf;
      logic [3:0] regsel_arf;
      logic       wr_mem;
      logic       cs_mem;
      logic       ir_enable;
      logic       ir_lh;
      logic [1:0] muxsel_a;
      logic [1:0] muxsel_b;
      logic       muxsel_c;
      logic [2:0] rf_o1sel;
      logic [2:0] rf_o2sel;
      logic [3:0] rf_tsel;
   } ctrl_t;

   // Safe idle word: nothing enabled, memory deselected, funsels parked on LOAD
   localparam ctrl_t CTRL_IDLE = '{
      halted: 1'b0, outasel: ARF_PC, outbsel: ARF_PC,
      funsel_ir: FS_LOAD, funsel_arf: FS_LOAD, funsel_rf: FS_LOAD, funsel_alu: ALU_PASSA,
      regsel_rf: 4'b0000, regsel_arf: 4'b0000, wr_mem: 1'b0, cs_mem: 1'b1,
      ir_enable: 1'b0, ir_lh: 1'b0, muxsel_a: MUX_ALU, muxsel_b: MUX_ALU,
      muxsel_c: MUXC_ARF, rf_o1sel: 3'd0, rf_o2sel: 3'd0, rf_tsel: 4'b0000
   };

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

   // ALU-class opcodes 0-7 map to ALU function codes
   function automatic logic [3:0] alu_code(input logic [2:0] op);
      logic [3:0] c;
      c = ALU_PASSA;
      case (op)
         3'd0: c = ALU_ADD;
         3'd1: c = ALU_SUB;
         3'd2: c = ALU_AND;
         3'd3: c = ALU_OR;
         3'd4: c = ALU_XOR;
         3'd5: c = ALU_NOT;
         3'd6: c = ALU_LSL;
         3'd7: c = ALU_LSR;
         default: c = ALU_PASSA;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational decode of (state, IR high byte, zq) into the full control word.
module cu_decoder
   import cpu_pkg::*;
#(
   parameter bit FETCH_HI_FIRST = 1'b1
) (
   input  state_e     state_i,
   input  logic [7:0] ir_i,
   input  logic       zq_i,
   output ctrl_t      ctrl_o
);

   logic [3:0] op;
   logic [1:0] rd, rs;
   assign op = ir_i[7:4];
   assign rd = ir_i[3:2];
   assign rs = ir_i[1:0];

   // Moore control word: start from idle and enable only what the state needs
   always_comb begin
      ctrl_o = CTRL_IDLE;
      case (state_i)
         S_FETCH1, S_FETCH2: begin
            ctrl_o.cs_mem     = 1'b0;
            ctrl_o.wr_mem     = 1'b0;
            ctrl_o.outasel    = ARF_PC;
            ctrl_o.ir_enable  = 1'b1;
            ctrl_o.ir_lh      = (state_i == S_FETCH1) ? FETCH_HI_FIRST : !FETCH_HI_FIRST;
            ctrl_o.funsel_ir  = FS_LOAD;
            ctrl_o.funsel_arf = FS_INC;
            ctrl_o.regsel_arf = onehot4(ARF_PC);
         end
         S_EXEC1: begin
            if (!op[3]) begin
               ctrl_o.muxsel_c   = MUXC_RF;
               ctrl_o.rf_o1sel   = {1'b0, rd};
               ctrl_o.rf_o2sel   = {1'b0, rs};
               ctrl_o.funsel_alu = alu_code(op[2:0]);
               ctrl_o.muxsel_a   = MUX_ALU;
               ctrl_o.regsel_rf  = onehot4(rd);
               ctrl_o.funsel_rf  = FS_LOAD;
            end else begin
               case (op)
                  OP_LDI: begin
                     ctrl_o.muxsel_a  = MUX_IMM;
                     ctrl_o.regsel_rf = onehot4(rd);
                  end
                  OP_LDM: begin
                     ctrl_o.outasel = ARF_AR;
                     ctrl_o.cs_mem  = 1'b0;
                  end
                  // Address and data settle here; memory stays deselected
                  OP_STM: begin
                     ctrl_o.outasel    = ARF_AR;
                     ctrl_o.muxsel_c   = MUXC_RF;
                     ctrl_o.rf_o1sel   = {1'b0, rs};
                     ctrl_o.funsel_alu = ALU_PASSA;
                  end
                  OP_LDAR: begin
                     ctrl_o.muxsel_b   = MUX_IMM;
                     ctrl_o.regsel_arf = onehot4(ARF_AR);
                     ctrl_o.funsel_arf = FS_LOAD;
                  end
                  OP_BRA: begin
                     ctrl_o.muxsel_b   = MUX_IMM;
                     ctrl_o.regsel_arf = onehot4(ARF_PC);
                     ctrl_o.funsel_arf = FS_LOAD;
                  end
                  OP_BEQ: begin
                     if (zq_i) begin
                        ctrl_o.muxsel_b   = MUX_IMM;
                        ctrl_o.regsel_arf = onehot4(ARF_PC);
                        ctrl_o.funsel_arf = FS_LOAD;
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_EXEC2: begin
            case (op)
               OP_LDM: begin
                  ctrl_o.outasel   = ARF_AR;
                  ctrl_o.cs_mem    = 1'b0;
                  ctrl_o.muxsel_a  = MUX_MEM;
                  ctrl_o.regsel_rf = onehot4(rd);
               end
               OP_STM: begin
                  ctrl_o.outasel    = ARF_AR;
                  ctrl_o.muxsel_c   = MUXC_RF;
                  ctrl_o.rf_o1sel   = {1'b0, rs};
                  ctrl_o.funsel_alu = ALU_PASSA;
                  ctrl_o.cs_mem     = 1'b0;
                  ctrl_o.wr_mem     = 1'b1;
               end
               default: ;
            endcase
         end
         S_HALT:  ctrl_o.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: holds the FSM and the zero flag, delegates the
// control word to cu_decoder, and forces a safe idle word while in reset.
module control_unit
   import cpu_pkg::*;
#(
   parameter bit FETCH_HI_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ir_out,
   input  logic [3:0]  alu_flag,
   output logic        halted,
   output logic [1:0]  outasel,
   output logic [1:0]  outbsel,
   output logic [1:0]  funsel_ir,
   output logic [1:0]  funsel_arf,
   output logic [1:0]  funsel_rf,
   output logic [3:0]  funsel_alu,
   output logic [3:0]  regsel_rf,
   output logic [3:0]  regsel_arf,
   output logic        wr_mem,
   output logic        cs_mem,
   output logic        ir_enable,
   output logic        ir_lh,
   output logic [1:0]  muxsel_a,
   output logic [1:0]  muxsel_b,
   output logic        muxsel_c,
   output logic [2:0]  rf_o1sel,
   output logic [2:0]  rf_o2sel,
   output logic [3:0]  rf_tsel
);

   state_e     state_q, state_d;
   logic       zq_q, zq_d;
   ctrl_t      dec_ctrl, ctrl;
   logic [3:0] op;
   logic       unused_in;

   assign op        = ir_out[15:12];
   assign unused_in = ^{ir_out[7:0], alu_flag[2:0]};

   // State and zero-flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH1;
         zq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         zq_q    <= zq_d;
      end
   end

   // Next state; zq captures Z only at the end of an ALU-op EXEC1
   always_comb begin
      state_d = state_q;
      zq_d    = zq_q;
      case (state_q)
         S_FETCH1: state_d = S_FETCH2;
         S_FETCH2: state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC1;
         S_EXEC1: begin
            if (!op[3]) zq_d = alu_flag[3];
            if (op == OP_LDM || op == OP_STM) state_d = S_EXEC2;
            else if (op == OP_HLT)            state_d = S_HALT;
            else                              state_d = S_FETCH1;
         end
         S_EXEC2: state_d = S_FETCH1;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH1;
      endcase
   end

   cu_decoder #(.FETCH_HI_FIRST(FETCH_HI_FIRST)) u_dec (
      .state_i (state_q),
      .ir_i    (ir_out[15:8]),
      .zq_i    (zq_q),
      .ctrl_o  (dec_ctrl)
   );

   // Reset overrides combinationally so a write in flight is cut off at once
   assign ctrl = rst_n ? dec_ctrl : CTRL_IDLE;

   assign halted     = ctrl.halted;
   assign outasel    = ctrl.outasel;
   assign outbsel    = ctrl.outbsel;
   assign funsel_ir  = ctrl.funsel_ir;
   assign funsel_arf = ctrl.funsel_arf;
   assign funsel_rf  = ctrl.funsel_rf;
   assign funsel_alu = ctrl.funsel_alu;
   assign regsel_rf  = ctrl.regsel_rf;
   assign regsel_arf = ctrl.regsel_arf;
   assign wr_mem     = ctrl.wr_mem;
   assign cs_mem     = ctrl.cs_mem;
   assign ir_enable  = ctrl.ir_enable;
   assign ir_lh      = ctrl.ir_lh;
   assign muxsel_a   = ctrl.muxsel_a;
   assign muxsel_b   = ctrl.muxsel_b;
   assign muxsel_c   = ctrl.muxsel_c;
   assign rf_o1sel   = ctrl.rf_o1sel;
   assign rf_o2sel   = ctrl.rf_o2sel;
   assign rf_tsel    = ctrl.rf_tsel;

endmodule
